// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        LOAD_STALL = 2'd1,
        FLUSH      = 2'd2
    } hz_state_t;

    localparam logic [4:0]  REG_ZERO  = 5'd0;
    localparam logic [31:0] NOP_INSTR = 32'd0;

    typedef struct packed {
        logic pc_write;
        logic ifid_write;
        logic ifid_flush;
        logic idex_bubble;
        logic pipe_hold;
    } hz_ctrl_t;

    localparam hz_ctrl_t CTRL_RUN   = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    localparam hz_ctrl_t CTRL_STALL = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    localparam hz_ctrl_t CTRL_FLUSH = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    localparam hz_ctrl_t CTRL_HOLD  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    localparam hz_ctrl_t CTRL_RST   = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

endpackage

// File: rtl/hazard_ctrl_load_use_detect.sv
// Combinational load-use comparator: a load in EX whose destination feeds the ID instruction.
module load_use_detect
    import hazard_pkg::*;
(
    input  logic [4:0] id_rs_i,
    input  logic [4:0] id_rt_i,
    input  logic       id_uses_rt_i,
    input  logic       ex_mem_read_i,
    input  logic [4:0] ex_rt_i,
    output logic       hazard_o
);

    logic rs_match;
    logic rt_match;

    assign rs_match = (ex_rt_i == id_rs_i);
    assign rt_match = id_uses_rt_i && (ex_rt_i == id_rt_i);
    // $0 is hardwired, so a load targeting it never creates a dependency.
    assign hazard_o = ex_mem_read_i && (ex_rt_i != REG_ZERO) && (rs_match || rt_match);

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller: load-use stalls, taken-branch flushes and memory freezes,
// plus a saturating stall-cycle counter and a sticky memory-timeout flag.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int BRANCH_PENALTY    = 1,
    parameter int MEM_TIMEOUT       = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  ID_rs,
    input  logic [4:0]  ID_rt,
    input  logic        ID_uses_rt,
    input  logic        ID_EX_MemRead,
    input  logic [4:0]  ID_EX_rt,
    input  logic        branch_taken,
    input  logic        mem_busy,
    output logic        PC_Write,
    output logic        IF_ID_Write,
    output logic        IF_ID_Flush,
    output logic        ID_EX_Bubble,
    output logic        pipe_hold,
    output logic [15:0] stall_cnt,
    output logic        mem_timeout
);

    localparam logic [3:0]  STALL_REM  = 4'(LOAD_STALL_CYCLES - 1);
    localparam logic [3:0]  FLUSH_REM  = 4'(BRANCH_PENALTY - 1);
    localparam logic [15:0] TIMEOUT_AT = 16'(MEM_TIMEOUT);

    hz_state_t   state_q, state_d;
    logic [3:0]  rem_q, rem_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic [15:0] busy_run_q, busy_run_d;
    logic        mem_timeout_q, mem_timeout_d;
    hz_ctrl_t    ctrl;
    logic        load_use;

    load_use_detect u_lud (
        .id_rs_i      (ID_rs),
        .id_rt_i      (ID_rt),
        .id_uses_rt_i (ID_uses_rt),
        .ex_mem_read_i(ID_EX_MemRead),
        .ex_rt_i      (ID_EX_rt),
        .hazard_o     (load_use)
    );

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        ctrl    = CTRL_RUN;
        if (rst) begin
            ctrl    = CTRL_RST;
            state_d = RUN;
            rem_d   = '0;
        end else if (mem_busy) begin
            ctrl = CTRL_HOLD;
        end else if (branch_taken) begin
            // A branch overrides any stall or flush in progress and restarts the penalty.
            ctrl = CTRL_FLUSH;
            if (BRANCH_PENALTY > 1) begin
                state_d = FLUSH;
                rem_d   = FLUSH_REM;
            end else begin
                state_d = RUN;
                rem_d   = '0;
            end
        end else begin
            unique case (state_q)
                FLUSH: begin
                    ctrl  = CTRL_FLUSH;
                    rem_d = rem_q - 4'd1;
                    if (rem_q == 4'd1) state_d = RUN;
                end
                LOAD_STALL: begin
                    ctrl  = CTRL_STALL;
                    rem_d = rem_q - 4'd1;
                    if (rem_q == 4'd1) state_d = RUN;
                end
                RUN: begin
                    if (load_use) begin
                        ctrl = CTRL_STALL;
                        if (LOAD_STALL_CYCLES > 1) begin
                            state_d = LOAD_STALL;
                            rem_d   = STALL_REM;
                        end
                    end
                end
                default: begin
                    state_d = RUN;
                    rem_d   = '0;
                end
            endcase
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (!ctrl.pc_write && stall_cnt_q != 16'hFFFF) stall_cnt_d = stall_cnt_q + 16'd1;

        busy_run_d = '0;
        if (mem_busy) busy_run_d = (busy_run_q == 16'hFFFF) ? busy_run_q : busy_run_q + 16'd1;

        mem_timeout_d = mem_timeout_q || (mem_busy && busy_run_d == TIMEOUT_AT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= RUN;
            rem_q         <= '0;
            stall_cnt_q   <= '0;
            busy_run_q    <= '0;
            mem_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            rem_q         <= rem_d;
            stall_cnt_q   <= stall_cnt_d;
            busy_run_q    <= busy_run_d;
            mem_timeout_q <= mem_timeout_d;
        end
    end

    assign PC_Write     = ctrl.pc_write;
    assign IF_ID_Write  = ctrl.ifid_write;
    assign IF_ID_Flush  = ctrl.ifid_flush;
    assign ID_EX_Bubble = ctrl.idex_bubble;
    assign pipe_hold    = ctrl.pipe_hold;
    assign stall_cnt    = stall_cnt_q;
    assign mem_timeout  = mem_timeout_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench: u_dut (3-cycle stall, 2-cycle flush, timeout 4) and u_dut1 (defaults) share inputs.
module tb_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  ID_rs, ID_rt, ID_EX_rt;
    logic        ID_uses_rt, ID_EX_MemRead, branch_taken, mem_busy;

    logic        pcw0, ifw0, ifl0, bub0, hold0, mt0;
    logic [15:0] cnt0;
    logic        pcw1, ifw1, ifl1, bub1, hold1, mt1;
    logic [15:0] cnt1;

    int checks = 0;
    int errors = 0;

    localparam logic [4:0] O_RUN   = 5'b11000;
    localparam logic [4:0] O_STALL = 5'b00010;
    localparam logic [4:0] O_FLUSH = 5'b11110;
    localparam logic [4:0] O_HOLD  = 5'b00001;
    localparam logic [4:0] O_RST   = 5'b00110;

    always #5 clk = ~clk;

    hazard_ctrl #(.LOAD_STALL_CYCLES(3), .BRANCH_PENALTY(2), .MEM_TIMEOUT(4)) u_dut (
        .clk(clk), .rst(rst), .ID_rs(ID_rs), .ID_rt(ID_rt), .ID_uses_rt(ID_uses_rt),
        .ID_EX_MemRead(ID_EX_MemRead), .ID_EX_rt(ID_EX_rt), .branch_taken(branch_taken),
        .mem_busy(mem_busy), .PC_Write(pcw0), .IF_ID_Write(ifw0), .IF_ID_Flush(ifl0),
        .ID_EX_Bubble(bub0), .pipe_hold(hold0), .stall_cnt(cnt0), .mem_timeout(mt0)
    );

    hazard_ctrl u_dut1 (
        .clk(clk), .rst(rst), .ID_rs(ID_rs), .ID_rt(ID_rt), .ID_uses_rt(ID_uses_rt),
        .ID_EX_MemRead(ID_EX_MemRead), .ID_EX_rt(ID_EX_rt), .branch_taken(branch_taken),
        .mem_busy(mem_busy), .PC_Write(pcw1), .IF_ID_Write(ifw1), .IF_ID_Flush(ifl1),
        .ID_EX_Bubble(bub1), .pipe_hold(hold1), .stall_cnt(cnt1), .mem_timeout(mt1)
    );

    wire [4:0] outs0 = {pcw0, ifw0, ifl0, bub0, hold0};
    wire [4:0] outs1 = {pcw1, ifw1, ifl1, bub1, hold1};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        ID_rs = 5'd0; ID_rt = 5'd0; ID_EX_rt = 5'd0;
        ID_uses_rt = 1'b0; ID_EX_MemRead = 1'b0; branch_taken = 1'b0; mem_busy = 1'b0;
    endtask

    task automatic load_use_rs8();
        ID_EX_MemRead = 1'b1; ID_EX_rt = 5'd8; ID_rs = 5'd8;
    endtask

    // Advance one edge and settle; inputs are then driven and checked mid-cycle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle();
        rst = 1'b1;
        #1 chk("rst_outs", 32'(outs0), 32'(O_RST));
        tick(); tick();
        chk("rst_cnt", 32'(cnt0), 0);
        chk("rst_mt", 32'(mt0), 0);
        rst = 1'b0;
        #1 chk("idle_outs", 32'(outs0), 32'(O_RUN));

        // 3-cycle load-use stall on dut0, 1-cycle on dut1
        load_use_rs8();
        #1 chk("lu_c1", 32'(outs0), 32'(O_STALL));
        chk("lu1_c1", 32'(outs1), 32'(O_STALL));
        tick(); idle();
        #1 chk("lu_c2", 32'(outs0), 32'(O_STALL));
        chk("lu1_c2", 32'(outs1), 32'(O_RUN));
        chk("lu_cnt1", 32'(cnt0), 1);
        tick();
        #1 chk("lu_c3", 32'(outs0), 32'(O_STALL));
        tick();
        #1 chk("lu_end", 32'(outs0), 32'(O_RUN));
        chk("lu_cnt3", 32'(cnt0), 3);
        chk("lu1_cnt", 32'(cnt1), 1);

        // comparator corner cases, combinational only
        ID_EX_MemRead = 1'b1; ID_EX_rt = 5'd0; ID_rs = 5'd0;
        #1 chk("lu_r0", 32'(outs0), 32'(O_RUN));
        ID_EX_rt = 5'd9; ID_rt = 5'd9; ID_rs = 5'd3; ID_uses_rt = 1'b0;
        #1 chk("lu_rt_unused", 32'(outs0), 32'(O_RUN));
        ID_uses_rt = 1'b1;
        #1 chk("lu_rt_used", 32'(outs0), 32'(O_STALL));
        ID_EX_MemRead = 1'b0;
        #1 chk("lu_noload", 32'(outs0), 32'(O_RUN));
        idle();

        // branch: 2-cycle flush on dut0, 1-cycle on dut1
        branch_taken = 1'b1;
        #1 chk("br_c1", 32'(outs0), 32'(O_FLUSH));
        tick(); idle();
        #1 chk("br_c2", 32'(outs0), 32'(O_FLUSH));
        chk("br1_c2", 32'(outs1), 32'(O_RUN));
        tick();
        #1 chk("br_end", 32'(outs0), 32'(O_RUN));
        chk("br_cnt", 32'(cnt0), 3);

        // branch cancels a stall in progress
        load_use_rs8();
        tick(); idle();
        branch_taken = 1'b1;
        #1 chk("lsbr_c1", 32'(outs0), 32'(O_FLUSH));
        tick(); idle();
        #1 chk("lsbr_c2", 32'(outs0), 32'(O_FLUSH));
        tick();
        #1 chk("lsbr_end", 32'(outs0), 32'(O_RUN));
        chk("lsbr_cnt", 32'(cnt0), 4);

        // reset mid flush
        branch_taken = 1'b1;
        tick(); idle();
        rst = 1'b1;
        #1 chk("rstfl_outs", 32'(outs0), 32'(O_RST));
        tick(); rst = 1'b0;
        #1 chk("rstfl_run", 32'(outs0), 32'(O_RUN));
        chk("rstfl_cnt", 32'(cnt0), 0);

        // freeze in the middle of a 3-cycle stall; timeout trips on the 4th busy edge
        load_use_rs8();
        tick(); idle();
        mem_busy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1 chk("mb_hold", 32'(outs0), 32'(O_HOLD));
            tick();
            chk("mb_mt", 32'(mt0), (i >= 3) ? 1 : 0);
        end
        mem_busy = 1'b0;
        #1 chk("mb_ls2", 32'(outs0), 32'(O_STALL));
        tick();
        #1 chk("mb_ls3", 32'(outs0), 32'(O_STALL));
        tick();
        #1 chk("mb_end", 32'(outs0), 32'(O_RUN));
        chk("mb_cnt", 32'(cnt0), 8);

        // branch held through a freeze is taken once memory is ready
        mem_busy = 1'b1; branch_taken = 1'b1;
        #1 chk("mbbr_hold", 32'(outs0), 32'(O_HOLD));
        tick(); tick();
        mem_busy = 1'b0;
        #1 chk("mbbr_c1", 32'(outs0), 32'(O_FLUSH));
        tick(); branch_taken = 1'b0;
        #1 chk("mbbr_c2", 32'(outs0), 32'(O_FLUSH));
        tick();
        #1 chk("mbbr_end", 32'(outs0), 32'(O_RUN));
        chk("mbbr_cnt", 32'(cnt0), 10);
        chk("mt_sticky", 32'(mt0), 1);

        rst = 1'b1;
        tick(); rst = 1'b0;
        chk("rst_mt_clr", 32'(mt0), 0);
        chk("rst_cnt_clr", 32'(cnt0), 0);

        // busy runs of 3 separated by a gap never reach the timeout
        mem_busy = 1'b1;
        tick(); tick(); tick();
        mem_busy = 1'b0;
        tick();
        mem_busy = 1'b1;
        tick(); tick(); tick();
        chk("mt_gap", 32'(mt0), 0);
        tick();
        chk("mt_run4", 32'(mt0), 1);

        // long freeze: counter saturates, default timeout of 1024 trips
        mem_busy = 1'b0;
        rst = 1'b1;
        tick(); rst = 1'b0;
        mem_busy = 1'b1;
        for (int i = 0; i < 65537; i++) tick();
        chk("sat_cnt", 32'(cnt0), 32'hFFFF);
        chk("sat1_cnt", 32'(cnt1), 32'hFFFF);
        chk("mt1_dflt", 32'(mt1), 1);
        tick();
        chk("sat_hold", 32'(cnt0), 32'hFFFF);
        mem_busy = 1'b0;
        #1 chk("sat_run", 32'(outs0), 32'(O_RUN));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
